// File: rtl/mem_stage.sv
// Memory-access stage: byte/half/word loads and stores over a req/ack data port,
// with a one-cycle pass-through for non-memory results and a bounded wait for ack.
module mem_stage #(
  parameter int TIMEOUT = 255,
  parameter int TW      = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_itype,
  input  logic [31:0] in_alu_out,
  input  logic [2:0]  in_funct3,
  input  logic [31:0] in_store_data,
  input  logic [4:0]  in_rd,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        out_valid,
  output logic [31:0] out_result,
  output logic [4:0]  out_rd,
  output logic        out_regwrite,
  output logic        out_fault
);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_ACCESS = 1'b1;

  localparam logic [2:0] IT_LOAD  = 3'b000;
  localparam logic [2:0] IT_ITYPE = 3'b001;
  localparam logic [2:0] IT_STORE = 3'b010;
  localparam logic [2:0] IT_RTYPE = 3'b011;

  localparam logic [TW-1:0] LIMIT = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [0:0]    state;
  logic [TW-1:0] cnt;
  logic [2:0]    f3_q;
  logic [1:0]    addr_lo;

  logic        is_mem;
  logic        is_pass;
  logic        legal_f3;
  logic        misaligned;
  logic        acc_fault;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic [31:0] lane;
  logic [31:0] load_val;
  logic        timeout_hit;

  assign in_ready    = (state == S_IDLE);
  assign dmem_req    = (state == S_ACCESS);
  assign timeout_hit = (TIMEOUT != 0) && (cnt == LIMIT);

  // Accept-time decode: legality, alignment and store lane steering.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    is_mem     = (in_itype == IT_LOAD) || (in_itype == IT_STORE);
    is_pass    = (in_itype == IT_RTYPE) || (in_itype == IT_ITYPE);
    legal_f3   = 1'b0;
    misaligned = 1'b0;
    be_next    = 4'b1111;
    wdata_next = in_store_data;
    if (in_itype == IT_LOAD)
      legal_f3 = (in_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    else if (in_itype == IT_STORE)
      legal_f3 = (in_funct3 inside {3'b000, 3'b001, 3'b010});
    case (in_funct3[1:0])
      2'b00: begin
        be_next    = 4'b0001 << in_alu_out[1:0];
        wdata_next = {4{in_store_data[7:0]}};
      end
      2'b01: begin
        misaligned = in_alu_out[0];
        be_next    = in_alu_out[1] ? 4'b1100 : 4'b0011;
        wdata_next = {2{in_store_data[15:0]}};
      end
      2'b10:   misaligned = (in_alu_out[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase
    acc_fault = is_mem && (!legal_f3 || misaligned);
  end

  // Load extraction from the lane selected by the captured low address bits.
  always_comb begin
    lane = dmem_rdata >> {addr_lo, 3'b000};
    case (f3_q)
      3'b000:  load_val = {{24{lane[7]}}, lane[7:0]};
      3'b001:  load_val = {{16{lane[15]}}, lane[15:0]};
      3'b100:  load_val = {24'd0, lane[7:0]};
      3'b101:  load_val = {16'd0, lane[15:0]};
      default: load_val = lane;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      cnt          <= '0;
      f3_q         <= '0;
      addr_lo      <= '0;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_be      <= '0;
      dmem_wdata   <= '0;
      out_valid    <= 1'b0;
      out_result   <= '0;
      out_rd       <= '0;
      out_regwrite <= 1'b0;
      out_fault    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      out_valid <= 1'b0;
      out_fault <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            out_rd <= in_rd;
            if (is_mem && !acc_fault) begin
              state      <= S_ACCESS;
              cnt        <= '0;
              f3_q       <= in_funct3;
              addr_lo    <= in_alu_out[1:0];
              dmem_we    <= (in_itype == IT_STORE);
              dmem_addr  <= {in_alu_out[31:2], 2'b00};
              dmem_be    <= (in_itype == IT_STORE) ? be_next : 4'b1111;
              dmem_wdata <= (in_itype == IT_STORE) ? wdata_next : 32'd0;
            end else begin
              out_valid    <= 1'b1;
              out_result   <= in_alu_out;
              out_fault    <= acc_fault;
              out_regwrite <= is_pass && (in_rd != 5'd0);
            end
          end
        end
        S_ACCESS: begin
          // Ack wins over the timeout when both land on the same edge.
          if (dmem_ack) begin
            state        <= S_IDLE;
            out_valid    <= 1'b1;
            out_result   <= dmem_we ? {dmem_addr[31:2], addr_lo} : load_val;
            out_regwrite <= !dmem_we && (out_rd != 5'd0);
          end else if (timeout_hit) begin
            state        <= S_IDLE;
            out_valid    <= 1'b1;
            out_fault    <= 1'b1;
            out_result   <= {dmem_addr[31:2], addr_lo};
            out_regwrite <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: pass-through, store steering, load extension,
// accept-time faults, timeout with TIMEOUT=4, and asynchronous reset mid-access.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_itype = '0;
  logic [31:0] in_alu_out = '0;
  logic [2:0]  in_funct3 = '0;
  logic [31:0] in_store_data = '0;
  logic [4:0]  in_rd = '0;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        out_valid;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        out_regwrite;
  logic        out_fault;

  int checks = 0;
  int failures = 0;

  mem_stage #(.TIMEOUT(4), .TW(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_itype(in_itype),
    .in_alu_out(in_alu_out), .in_funct3(in_funct3),
    .in_store_data(in_store_data), .in_rd(in_rd),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .out_valid(out_valid), .out_result(out_result), .out_rd(out_rd),
    .out_regwrite(out_regwrite), .out_fault(out_fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one entry for exactly one accepting edge, then withdraw it.
  task automatic issue(input logic [2:0] it, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] sd, input logic [4:0] rd);
    in_valid = 1'b1; in_itype = it; in_funct3 = f3;
    in_alu_out = addr; in_store_data = sd; in_rd = rd;
    step();
    in_valid = 1'b0;
  endtask

  task automatic ack_now(input logic [31:0] data);
    dmem_rdata = data; dmem_ack = 1'b1;
    step();
    dmem_ack = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check("rst_ready", in_ready, 1);
    check("rst_req", dmem_req, 0);
    check("rst_valid", out_valid, 0);
    check("rst_result", out_result, 0);
    step();
    rst_n = 1'b1;
    step();

    // RTYPE pass-through
    issue(3'b011, 3'b000, 32'h0000_0042, 32'h0, 5'd5);
    check("rt_valid", out_valid, 1);
    check("rt_result", out_result, 32'h42);
    check("rt_rd", out_rd, 5);
    check("rt_regwrite", out_regwrite, 1);
    check("rt_req", dmem_req, 0);
    step();
    check("rt_pulse_end", out_valid, 0);

    // ITYPE to x0 and BRANCH: no writeback
    issue(3'b001, 3'b000, 32'h1234, 32'h0, 5'd0);
    check("it_x0_valid", out_valid, 1);
    check("it_x0_regwrite", out_regwrite, 0);
    issue(3'b110, 3'b000, 32'h99, 32'h0, 5'd4);
    check("br_valid", out_valid, 1);
    check("br_regwrite", out_regwrite, 0);
    check("br_fault", out_fault, 0);

    // SB at 0x1003
    issue(3'b010, 3'b000, 32'h1003, 32'hAABB_CCDD, 5'd0);
    check("sb_req", dmem_req, 1);
    check("sb_we", dmem_we, 1);
    check("sb_addr", dmem_addr, 32'h1000);
    check("sb_be", dmem_be, 4'b1000);
    check("sb_wdata", dmem_wdata, 32'hDDDD_DDDD);
    check("sb_ready_low", in_ready, 0);
    check("sb_no_pulse", out_valid, 0);
    ack_now(32'h0);
    check("sb_done_valid", out_valid, 1);
    check("sb_done_regwrite", out_regwrite, 0);
    check("sb_done_fault", out_fault, 0);
    check("sb_done_req", dmem_req, 0);
    check("sb_done_ready", in_ready, 1);

    // SH at 0x1002 and SW at 0x1004
    issue(3'b010, 3'b001, 32'h1002, 32'hAABB_CCDD, 5'd0);
    check("sh_be", dmem_be, 4'b1100);
    check("sh_wdata", dmem_wdata, 32'hCCDD_CCDD);
    ack_now(32'h0);
    issue(3'b010, 3'b010, 32'h1004, 32'hAABB_CCDD, 5'd0);
    check("sw_addr", dmem_addr, 32'h1004);
    check("sw_be", dmem_be, 4'b1111);
    check("sw_wdata", dmem_wdata, 32'hAABB_CCDD);
    ack_now(32'h0);

    // LB / LBU at 0x2001 with rdata 0x000080FF
    issue(3'b000, 3'b000, 32'h2001, 32'h0, 5'd7);
    check("lb_req", dmem_req, 1);
    check("lb_we", dmem_we, 0);
    check("lb_addr", dmem_addr, 32'h2000);
    ack_now(32'h0000_80FF);
    check("lb_valid", out_valid, 1);
    check("lb_result", out_result, 32'hFFFF_FF80);
    check("lb_rd", out_rd, 7);
    check("lb_regwrite", out_regwrite, 1);
    issue(3'b000, 3'b100, 32'h2001, 32'h0, 5'd7);
    ack_now(32'h0000_80FF);
    check("lbu_result", out_result, 32'h0000_0080);

    // LH / LHU at 0x2002 with one wait cycle
    issue(3'b000, 3'b001, 32'h2002, 32'h0, 5'd9);
    step();
    check("lh_wait_valid", out_valid, 0);
    check("lh_wait_req", dmem_req, 1);
    ack_now(32'h8001_0000);
    check("lh_result", out_result, 32'hFFFF_8001);
    issue(3'b000, 3'b101, 32'h2002, 32'h0, 5'd9);
    ack_now(32'h8001_0000);
    check("lhu_result", out_result, 32'h0000_8001);

    // Load to x0 completes without writeback
    issue(3'b000, 3'b010, 32'h2000, 32'h0, 5'd0);
    ack_now(32'h1234_5678);
    check("lw_x0_result", out_result, 32'h1234_5678);
    check("lw_x0_regwrite", out_regwrite, 0);

    // Accept-time faults
    issue(3'b000, 3'b001, 32'h3001, 32'h0, 5'd6);
    check("lh_mis_req", dmem_req, 0);
    check("lh_mis_valid", out_valid, 1);
    check("lh_mis_fault", out_fault, 1);
    check("lh_mis_regwrite", out_regwrite, 0);
    check("lh_mis_result", out_result, 32'h3001);
    issue(3'b000, 3'b011, 32'h3000, 32'h0, 5'd6);
    check("lw_f3_fault", out_fault, 1);
    check("lw_f3_req", dmem_req, 0);
    issue(3'b010, 3'b010, 32'h3002, 32'h0, 5'd0);
    check("sw_mis_fault", out_fault, 1);
    step();
    check("fault_pulse_end", out_fault, 0);

    // Timeout: req held four cycles then fault
    issue(3'b000, 3'b010, 32'h4000, 32'h0, 5'd3);
    for (int i = 0; i < 3; i++) begin
      check("to_req_held", dmem_req, 1);
      step();
    end
    check("to_req_cycle4", dmem_req, 1);
    step();
    check("to_req_drop", dmem_req, 0);
    check("to_valid", out_valid, 1);
    check("to_fault", out_fault, 1);
    check("to_regwrite", out_regwrite, 0);

    // Ack in the fourth cycle beats the limit
    issue(3'b000, 3'b010, 32'h4000, 32'h0, 5'd3);
    step(); step(); step();
    check("to_ack_req", dmem_req, 1);
    ack_now(32'hCAFE_F00D);
    check("to_ack_valid", out_valid, 1);
    check("to_ack_fault", out_fault, 0);
    check("to_ack_result", out_result, 32'hCAFE_F00D);
    check("to_ack_regwrite", out_regwrite, 1);

    // Asynchronous reset in the middle of a wait
    issue(3'b000, 3'b010, 32'h5000, 32'h0, 5'd8);
    step();
    check("ar_req_before", dmem_req, 1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_req_async", dmem_req, 0);
    check("ar_valid_async", out_valid, 0);
    check("ar_ready_async", in_ready, 1);
    step();
    rst_n = 1'b1;
    ack_now(32'h1111_1111);
    check("ar_ack_ignored", out_valid, 0);
    check("ar_ready_after", in_ready, 1);
    step();
    check("ar_no_pulse", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage pipeline, directly downstream of the execute-stage ALU. It takes the ALU result, the forwarded funct3, the instruction type, the store data and the destination register from the EX/MEM boundary. It performs byte, half and word loads and stores against a req/ack data-memory port, with lane steering and load sign/zero extension. It hands a registered result to writeback, or passes non-memory results through in one cycle.

## Interface
- TIMEOUT, 255: consecutive ACCESS cycles without `dmem_ack` before the access is abandoned with a fault; 0 disables the timeout.
- TW, 8: width of the timeout counter; must satisfy TIMEOUT < 2^TW.

- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  EX/MEM entry is valid this cycle.
- in_ready  out  1  stage can accept; combinational, high only in IDLE.
- in_itype  in  3  000 LOAD, 010 STORE, 011 RTYPE, 001 ITYPE, 110 BRANCH.
- in_alu_out  in  32  ALU result; this is the byte address for LOAD/STORE.
- in_funct3  in  3  forwarded funct3.
- in_store_data  in  32  rs2 value for stores.
- in_rd  in  5  destination register.
- dmem_req  out  1  access request, held until ack.
- dmem_we  out  1  1 for store.
- dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
- dmem_be  out  4  byte enables.
- dmem_wdata  out  32  lane-steered store data.
- dmem_ack  in  1  access complete; `dmem_rdata` valid in the same cycle.
- dmem_rdata  in  32  read word.
- out_valid  out  1  one-cycle result pulse to writeback.
- out_result  out  32  writeback value.
- out_rd  out  5  destination register.
- out_regwrite  out  1  writeback enable.
- out_fault  out  1  misaligned, illegal funct3, or timeout.

## Operation
- FSM states: IDLE and ACCESS. Writeback never stalls, so `out_valid` is a single-cycle pulse.
- Accept occurs when `in_valid && in_ready` at a rising edge. All inputs are captured at that edge.
- RTYPE/ITYPE, pass-through: `out_result` = `in_alu_out` and `out_regwrite` = 1, unless `in_rd` == 0, which gives regwrite 0.
- BRANCH or any unlisted itype: `out_valid` pulses with `out_regwrite` = 0.
- Legal load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- Legal store funct3: 000 SB, 001 SH, 010 SW.
- Fault on accept: an illegal funct3, a half access with addr[0] = 1, or a word access with addr[1:0] ≠ 0.
  - No memory request is issued.
  - `out_valid` and `out_fault` pulse next cycle; `out_regwrite` = 0; `out_result` = address.
- Legal LOAD/STORE → ACCESS.
  - `dmem_req` = 1; `dmem_addr`, `dmem_we`, `dmem_be` and `dmem_wdata` are held stable until ack.
- Store steering:
  - SB: be = 1 << addr[1:0]; wdata = the byte replicated ×4.
  - SH: be = addr[1] ? 1100 : 0011; wdata = the half replicated ×2.
  - SW: be = 1111; wdata = the data as-is.
- Load extraction: lane = rdata >> (8·addr[1:0]).
  - LB and LH sign-extend.
  - LBU and LHU zero-extend.
  - LW takes the full word.
- ACCESS with `dmem_ack` = 1 → IDLE.
  - `dmem_req` drops on the next edge.
  - Result pulse: regwrite = 1 for loads with rd ≠ 0, and 0 for stores.
- Timeout: the counter clears on entry to ACCESS and increments each ACCESS cycle with ack low.
  - Reaching TIMEOUT → IDLE, with a fault pulse and regwrite 0.
  - An ack arriving in the same cycle as the limit wins: normal completion, no fault.

## Timing
- Reset (async, `rst_n` low): state IDLE, counter 0, and all registered outputs 0.
  - `dmem_req` and `out_valid` fall immediately.
  - `in_ready` = 1.
  - An in-flight access is abandoned with no result pulse.
- Pass-through or fault: accept at edge T → `out_valid` high during T..T+1, i.e. a latency of 1 cycle.
- Memory op: accept at edge T → `dmem_req` high from T.
  - If ack is sampled at edge T+1+k (k wait cycles), the result pulse falls in the cycle after that edge.
  - Latency is therefore 2+k cycles.
- `in_ready` is low throughout ACCESS. It rises in the cycle the result pulse is presented, so back-to-back accepts are possible.
- `dmem_ack` is ignored outside ACCESS.

## Test plan
- RTYPE with alu_out = 0x0000_0042 and rd = 5 → one cycle later: out_valid, result 0x42, rd 5, regwrite 1, no dmem_req.
- SB at address 0x1003 with data 0xAABBCCDD → dmem_addr 0x1000, be 1000, wdata 0xDDDDDDDD. After the ack: regwrite 0, fault 0.
- LB at address 0x2001 with rdata 0x0000_80FF → result 0xFFFF_FF80. Repeated as LBU → result 0x0000_0080.
- LH at address 0x3001 → no dmem_req; out_fault pulse 1 cycle later; regwrite 0. LW with funct3 = 011 → fault.
- LW with ack held low and TIMEOUT = 4 → dmem_req is high 4 cycles, then drops; fault pulse follows. With ack in the 4th cycle → normal result, no fault.
- LW with ack delayed 3 cycles, rst_n pulsed low mid-wait → dmem_req and out_valid drop asynchronously, no result pulse, and in_ready = 1 after release.
